// File: rtl/axi4_sram_responder.sv
// axi4_sram_responder: AXI4 slave backed by a word-addressed 32-bit SRAM (FIXED/INCR/WRAP bursts).
// Define AXI4_SRAM_RAND_STALL_EN to add LFSR-driven ready/valid stalls.
module axi4_sram_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned ID_W        = 4
) (
    input  logic            clock,
    input  logic            reset,
    output logic            awready,
    input  logic            awvalid,
    input  logic [31:0]     awaddr,
    input  logic [ID_W-1:0] awid,
    input  logic [7:0]      awlen,
    input  logic [2:0]      awsize,
    input  logic [1:0]      awburst,
    output logic            wready,
    input  logic            wvalid,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wlast,
    input  logic            bready,
    output logic            bvalid,
    output logic [1:0]      bresp,
    output logic [ID_W-1:0] bid,
    output logic            arready,
    input  logic            arvalid,
    input  logic [31:0]     araddr,
    input  logic [ID_W-1:0] arid,
    input  logic [7:0]      arlen,
    input  logic [2:0]      arsize,
    input  logic [1:0]      arburst,
    input  logic            rready,
    output logic            rvalid,
    output logic [1:0]      rresp,
    output logic [31:0]     rdata,
    output logic            rlast,
    output logic [ID_W-1:0] rid
);
    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    function automatic logic wrap_ok(input logic [7:0] len);
        return len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15;
    endfunction

    function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
        return burst == 2'b11 || (burst == 2'b10 && !wrap_ok(len));
    endfunction

    function automatic logic in_range(input logic [31:0] a);
        return (a - BASE_ADDR) < SPAN;
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

    // WRAP windows are power-of-two sized, so wrapping is a mask of the low bits.
    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] step, wrap_bytes;
        step = 32'd1 << size;
        wrap_bytes = (32'(len) + 32'd1) << size;
        if (burst == 2'b00) return a;
        if (burst == 2'b10 && wrap_ok(len))
            return (a & ~(wrap_bytes - 32'd1)) | ((a + step) & (wrap_bytes - 32'd1));
        return a + step;
    endfunction

    logic hold_a, hold_r;
`ifdef AXI4_SRAM_RAND_STALL_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clock or posedge reset)
        if (reset) lfsr_q <= 16'hACE1;
        else lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign hold_a = lfsr_q[0];
    assign hold_r = lfsr_q[1];
`else
    assign hold_a = 1'b0;
    assign hold_r = 1'b0;
`endif

    logic [31:0] mem [DEPTH_WORDS];

    w_state_e        w_state_q, w_state_d;
    logic [31:0]     aw_addr_q;
    logic [ID_W-1:0] aw_id_q;
    logic [7:0]      aw_len_q, w_cnt_q;
    logic [2:0]      aw_size_q;
    logic [1:0]      aw_burst_q;
    logic            w_err_q, aw_hs, w_hs, w_last_beat, mem_we;

    assign awready     = w_state_q == W_IDLE && !hold_a;
    assign wready      = w_state_q == W_DATA && !hold_a;
    assign bvalid      = w_state_q == W_RESP;
    assign bresp       = {bvalid & w_err_q, 1'b0};
    assign bid         = aw_id_q;
    assign aw_hs       = awvalid & awready;
    assign w_hs        = wvalid & wready;
    assign w_last_beat = w_cnt_q == aw_len_q;
    assign mem_we      = w_hs && in_range(aw_addr_q) && aw_burst_q != 2'b11;

    always_comb begin
        w_state_d = aw_hs ? W_DATA : (w_hs && w_last_beat) ? W_RESP : (bvalid && bready) ? W_IDLE : w_state_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_state_q  <= W_IDLE;
            aw_addr_q  <= '0;
            aw_id_q    <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            w_cnt_q    <= '0;
            w_err_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            if (aw_hs) begin
                aw_addr_q  <= awaddr;
                aw_id_q    <= awid;
                aw_len_q   <= awlen;
                aw_size_q  <= awsize;
                aw_burst_q <= awburst;
                w_cnt_q    <= '0;
                w_err_q    <= burst_err(awburst, awlen);
            end
            if (w_hs) begin
                aw_addr_q <= next_addr(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q);
                w_cnt_q   <= w_cnt_q + 8'd1;
                w_err_q   <= w_err_q | !in_range(aw_addr_q) | (wlast != w_last_beat);
            end
        end
    end

    always_ff @(posedge clock)
        if (mem_we)
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) mem[word_idx(aw_addr_q)][8*b +: 8] <= wdata[8*b +: 8];

    r_state_e        r_state_q, r_state_d;
    logic [31:0]     ar_addr_q, r_addr_d, rdata_q;
    logic [ID_W-1:0] ar_id_q;
    logic [7:0]      ar_len_q, r_cnt_q, r_cnt_d, r_len;
    logic [2:0]      ar_size_q;
    logic [1:0]      ar_burst_q, r_burst, rresp_q;
    logic            r_valid_q, rlast_q, ar_hs, r_hs, r_issue, r_ok, r_err;

    assign arready = r_state_q == R_IDLE && !hold_a;
    assign rvalid  = r_valid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rid     = ar_id_q;
    assign ar_hs   = arvalid & arready;
    assign r_hs    = rvalid & rready;

    // A memory read is issued on the AR handshake and on every non-final beat acceptance.
    always_comb begin
        r_issue   = ar_hs | (r_hs & ~rlast_q);
        r_addr_d  = ar_hs ? araddr : next_addr(ar_addr_q, ar_len_q, ar_size_q, ar_burst_q);
        r_burst   = ar_hs ? arburst : ar_burst_q;
        r_len     = ar_hs ? arlen : ar_len_q;
        r_cnt_d   = ar_hs ? 8'd0 : r_cnt_q + 8'd1;
        r_ok      = in_range(r_addr_d) && r_burst != 2'b11;
        r_err     = !in_range(r_addr_d) || burst_err(r_burst, r_len);
        r_state_d = ar_hs ? R_DATA : (r_hs && rlast_q) ? R_IDLE : r_state_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state_q  <= R_IDLE;
            ar_addr_q  <= '0;
            ar_id_q    <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            r_cnt_q    <= '0;
            r_valid_q  <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            rlast_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            if (ar_hs) begin
                ar_id_q    <= arid;
                ar_len_q   <= arlen;
                ar_size_q  <= arsize;
                ar_burst_q <= arburst;
            end
            if (r_issue) begin
                ar_addr_q <= r_addr_d;
                r_cnt_q   <= r_cnt_d;
                rdata_q   <= r_ok ? mem[word_idx(r_addr_d)] : 32'd0;
                rresp_q   <= {r_err, 1'b0};
                rlast_q   <= r_cnt_d == r_len;
                r_valid_q <= !hold_r;
            end else if (r_hs) begin
                r_valid_q <= 1'b0;
                rlast_q   <= 1'b0;
            end else if (r_state_q == R_DATA) begin
                r_valid_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axi4_sram_responder.sv
// tb_axi4_sram_responder: scoreboard bench for axi4_sram_responder with a behavioural memory model.
module tb_axi4_sram_responder;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          ID_W  = 4;

    logic clock = 1'b0, reset;
    logic awready, awvalid, wready, wvalid, wlast, bready, bvalid, arready, arvalid, rready, rvalid, rlast;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [ID_W-1:0] awid, bid, arid, rid;
    logic [7:0] awlen, arlen;
    logic [2:0] awsize, arsize;
    logic [1:0] awburst, arburst, bresp, rresp;
    logic [3:0] wstrb;

    axi4_sram_responder dut (
        .clock(clock), .reset(reset),
        .awready(awready), .awvalid(awvalid), .awaddr(awaddr), .awid(awid), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bready(bready), .bvalid(bvalid), .bresp(bresp), .bid(bid),
        .arready(arready), .arvalid(arvalid), .araddr(araddr), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata), .rlast(rlast), .rid(rid)
    );

    always #5 clock = ~clock;

    typedef struct packed {logic [31:0] data; logic [1:0] resp; logic last; logic [ID_W-1:0] id;} r_exp_t;
    typedef struct packed {logic [1:0] resp; logic [ID_W-1:0] id;} b_exp_t;

    int n_chk = 0, n_fail = 0, rr_mode = 0;
    logic [31:0] mdl [DEPTH];
    r_exp_t exp_r[$];
    b_exp_t exp_b[$];
    r_exp_t er, held;
    b_exp_t eb;
    logic stall_seen = 1'b0;
    logic [31:0] dq[$];
    logic [3:0] sq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic in_win(input logic [31:0] a);
        return a >= BASE && a < BASE + 32'(4 * DEPTH);
    endfunction

    function automatic logic bad_burst(input logic [1:0] burst, input int len);
        return burst == 2'b11 || (burst == 2'b10 && !(len inside {1, 3, 7, 15}));
    endfunction

    // Address of beat i straight from the burst definitions.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int size,
                                              input logic [1:0] burst, input int i);
        longint step, wb, lo;
        step = longint'(1) << size;
        if (burst == 2'b00) return a;
        if (burst == 2'b10 && !bad_burst(burst, len)) begin
            wb = (len + 1) * step;
            lo = longint'(a) - (longint'(a) % wb);
            return 32'(lo + ((longint'(a) - lo + i * step) % wb));
        end
        return 32'(longint'(a) + i * step);
    endfunction

    always @(posedge clock) begin
        #1;
        rready = rr_mode == 0 ? 1'b1 : rr_mode == 1 ? !rready : rr_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
        bready = rr_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clock) begin
        if (reset) stall_seen = 1'b0;
        else begin
            if (stall_seen) begin
                chk("r_hold_valid", rvalid, 1);
                chk("r_hold_beat", {rdata, rresp, rlast, rid}, held);
            end
            if (bvalid && bready) begin
                chk("b_pending", exp_b.size() != 0, 1);
                if (exp_b.size() != 0) begin
                    eb = exp_b.pop_front();
                    chk("b_resp", bresp, eb.resp);
                    chk("b_id", bid, eb.id);
                end
            end
            if (rvalid && rready) begin
                chk("r_pending", exp_r.size() != 0, 1);
                if (exp_r.size() != 0) begin
                    er = exp_r.pop_front();
                    chk("r_data", rdata, er.data);
                    chk("r_resp", rresp, er.resp);
                    chk("r_last", rlast, er.last);
                    chk("r_id", rid, er.id);
                end
            end
            stall_seen = rvalid && !rready;
            held = {rdata, rresp, rlast, rid};
        end
    end

    task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] size, input logic [1:0] burst,
                            input logic [ID_W-1:0] id, input logic [31:0] d[$], input logic [3:0] s[$], input bit bad_last);
        logic err;
        logic [31:0] a;
        int n;
        err = bad_burst(burst, len) || bad_last;
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, len, size, burst, i);
            if (!in_win(a)) err = 1'b1;
            else if (burst != 2'b11)
                for (int b = 0; b < 4; b++)
                    if (s[i][b]) mdl[(a - BASE) >> 2][8*b +: 8] = d[i][8*b +: 8];
        end
        exp_b.push_back('{resp: err ? 2'b10 : 2'b00, id: id});
        awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awid = id; awvalid = 1'b1;
        n = 0;
        do begin @(negedge clock); n++; end while (!awready && n < 50);
        chk("aw_accept", awready, 1);
        @(posedge clock); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wvalid = 1'b1; wdata = d[i]; wstrb = s[i]; wlast = (i == len) && !bad_last;
            n = 0;
            do begin @(negedge clock); n++; end while (!wready && n < 50);
            chk("w_accept", wready, 1);
            @(posedge clock); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        while (exp_b.size() != 0 && n < 200) begin @(negedge clock); n++; end
        chk("b_drained", exp_b.size(), 0);
        exp_b.delete();
        @(posedge clock); #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input logic [2:0] size, input logic [1:0] burst,
                           input logic [ID_W-1:0] id);
        logic [31:0] a;
        r_exp_t e;
        int n;
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, len, size, burst, i);
            e.data = (in_win(a) && burst != 2'b11) ? mdl[(a - BASE) >> 2] : 32'd0;
            e.resp = (!in_win(a) || bad_burst(burst, len)) ? 2'b10 : 2'b00;
            e.last = i == len;
            e.id = id;
            exp_r.push_back(e);
        end
        araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
        n = 0;
        do begin @(negedge clock); n++; end while (!arready && n < 50);
        chk("ar_accept", arready, 1);
        @(posedge clock); #1;
        arvalid = 1'b0;
        @(negedge clock);
        chk("r_latency", rvalid, 1);
        n = 0;
        while (exp_r.size() != 0 && n < 3000) begin @(negedge clock); n++; end
        chk("r_drained", exp_r.size(), 0);
        exp_r.delete();
        @(posedge clock); #1;
    endtask

    task automatic load(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3,
                        input int cnt, input logic [3:0] strb);
        dq.delete(); sq.delete();
        dq.push_back(w0); dq.push_back(w1); dq.push_back(w2); dq.push_back(w3);
        while (dq.size() > cnt) void'(dq.pop_back());
        for (int i = 0; i < cnt; i++) sq.push_back(strb);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] sz;
        logic [1:0] bt;
        logic [31:0] ad;
        int ln, n;
        reset = 1'b1; rready = 1'b1; bready = 1'b1;
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", {awready, arready, wready}, 3'b110);
        chk("rst_valid", {bvalid, rvalid, rlast}, 3'b000);
        chk("rst_resp", {bresp, rresp}, 4'h0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ids", {bid, rid}, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        for (int k = 0; k < 16; k++) begin
            dq.delete(); sq.delete();
            for (int i = 0; i < 256; i++) begin dq.push_back($urandom); sq.push_back(4'hF); end
            do_write(BASE + 32'(k * 1024), 255, 3'd2, 2'b01, 4'(k), dq, sq, 1'b0);
        end

        load(32'hDEADBEEF, 0, 0, 0, 1, 4'hF);
        do_write(BASE + 32'h10, 0, 3'd2, 2'b01, 4'h1, dq, sq, 1'b0);
        do_read(BASE + 32'h10, 0, 3'd2, 2'b01, 4'h2);

        load(1, 2, 3, 4, 4, 4'hF);
        do_write(BASE, 3, 3'd2, 2'b01, 4'h5, dq, sq, 1'b0);
        do_read(BASE, 3, 3'd2, 2'b01, 4'h9);
        do_read(BASE + 32'h08, 3, 3'd2, 2'b10, 4'hA);

        rr_mode = 1;
        do_read(BASE, 7, 3'd2, 2'b01, 4'h3);
        rr_mode = 0;
        load(32'h0000ABCD, 0, 0, 0, 1, 4'b0011);
        do_write(BASE + 32'h10, 0, 3'd2, 2'b01, 4'h4, dq, sq, 1'b0);
        do_read(BASE + 32'h10, 0, 3'd2, 2'b01, 4'h6);

        load(32'h11111111, 32'h22222222, 0, 0, 2, 4'hF);
        do_write(BASE + 32'(4 * DEPTH), 1, 3'd2, 2'b01, 4'h7, dq, sq, 1'b0);
        do_read(BASE, 1, 3'd2, 2'b01, 4'h7);
        load(32'hA5A5A5A5, 32'h5A5A5A5A, 0, 0, 2, 4'hF);
        do_write(BASE + 32'h40, 1, 3'd2, 2'b01, 4'h8, dq, sq, 1'b1);
        do_read(BASE + 32'h40, 1, 3'd2, 2'b01, 4'h8);
        load(32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003, 0, 3, 4'hF);
        do_write(BASE + 32'h80, 2, 3'd2, 2'b11, 4'hB, dq, sq, 1'b0);
        do_read(BASE + 32'h80, 2, 3'd2, 2'b11, 4'hB);
        do_read(BASE + 32'h80, 2, 3'd2, 2'b10, 4'hC);
        load(32'h0A, 32'h0B, 32'h0C, 32'h0D, 4, 4'hF);
        do_write(BASE + 32'hC0, 3, 3'd2, 2'b00, 4'hD, dq, sq, 1'b0);
        do_read(BASE + 32'hC0, 3, 3'd2, 2'b00, 4'hE);
        do_read(BASE + 32'(4 * DEPTH) - 32'd8, 3, 3'd2, 2'b01, 4'hF);

        for (int t = 0; t < 60; t++) begin
            rr_mode = $urandom_range(0, 2);
            sz = 3'($urandom_range(0, 2));
            bt = 2'($urandom_range(0, 2));
            ln = $urandom_range(0, 15);
            ad = BASE + (32'($urandom_range(0, 4 * DEPTH - 1)) & ~((32'd1 << sz) - 32'd1));
            if ($urandom_range(0, 7) == 0) ad = BASE + 32'(4 * DEPTH) - 32'd8;
            if ($urandom_range(0, 1) == 1) begin
                dq.delete(); sq.delete();
                for (int i = 0; i <= ln; i++) begin dq.push_back($urandom); sq.push_back(4'($urandom)); end
                do_write(ad, ln, sz, bt, 4'($urandom), dq, sq, $urandom_range(0, 7) == 0);
            end else
                do_read(ad, ln, sz, bt, 4'($urandom));
        end

        rr_mode = 3;
        repeat (2) @(posedge clock);
        #1;
        araddr = BASE; arlen = 8'd15; arsize = 3'd2; arburst = 2'b01; arid = 4'h7; arvalid = 1'b1;
        n = 0;
        do begin @(negedge clock); n++; end while (!arready && n < 50);
        chk("ar_accept_mid", arready, 1);
        @(posedge clock); #1;
        arvalid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("pre_rst_rvalid", rvalid, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_ready", {arready, awready}, 2'b11);
        chk("mid_rst_rlast_rdata", {rlast, rdata}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        rr_mode = 0;
        @(posedge clock); #1;
        do_read(BASE + 32'h10, 0, 3'd2, 2'b01, 4'h3);

        chk("queues_empty", exp_r.size() + exp_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
